// File: rtl/seven_seg_scan_if.sv
// Display-register side of the seven-segment scanner: latch strobe, digit data
// and the multiplexed pin outputs.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output en,
    output load,
    output value_in,
    output dp_in,
    output blank_in,
    input  seg_out,
    input  dp_out,
    input  dig_sel,
    input  frame_done
  );

  modport slave (
    input  en,
    input  load,
    input  value_in,
    input  dp_in,
    input  blank_in,
    output seg_out,
    output dp_out,
    output dig_sel,
    output frame_done
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver: shadow-latched nibbles, prescaled
// digit scan, hex/decimal decode, blanking, leading-zero suppression, pin polarity.
module seven_seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int HEX_MODE       = 1,
  parameter int BLANK_LEADING  = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               rst,
  seven_seg_scan_if.slave   bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_done;

  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_suppress;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_tick;
  logic                    w_dark;
  logic [3:0]              w_nib_sel;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;

  // Active-high segment pattern {a,b,c,d,e,f,g}; letters only when HEX_MODE is set.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'hB:    seg = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
      4'hC:    seg = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
      4'hD:    seg = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
      4'hE:    seg = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
      default: seg = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
    endcase
    return seg;
  endfunction

  // w_upper_zero[k] means nibbles k..NUM_DIGITS-1 of the shadow are all zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_nib[gi] = r_value[4*gi +: 4];
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_upper_zero[gi] = (w_nib[gi] == 4'h0);
    end else begin : g_lower
      assign w_upper_zero[gi] = (w_nib[gi] == 4'h0) && w_upper_zero[gi+1];
    end
    assign w_suppress[gi] = (gi != 0) && (BLANK_LEADING != 0) && w_upper_zero[gi];
    assign w_onehot[gi]   = (r_idx == IDX_W'(gi));
  end

  assign w_tick     = (r_cnt == LAST_CNT) && bus.en;
  assign w_nib_sel  = w_nib[r_idx];
  assign w_dark     = r_blank[r_idx] || w_suppress[r_idx];
  assign w_seg_next = w_dark ? 7'b0000000 : f_decode(w_nib_sel);
  assign w_dp_next  = !w_dark && r_dp[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_blank <= '0;
    end else if (bus.load) begin
      r_value <= bus.value_in;
      r_dp    <= bus.dp_in;
      r_blank <= bus.blank_in;
    end
  end

  // Prescaler and digit index only advance while enabled, so a paused scan resumes in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else if (bus.en) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_frame_done <= w_tick && (r_idx == LAST_IDX);
    end
  end

  // Pin registers hold the logical (active-high) value; zero means dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= '0;
      r_dp_out <= 1'b0;
      r_dig    <= '0;
    end else if (bus.en) begin
      r_seg    <= w_seg_next;
      r_dp_out <= w_dp_next;
      r_dig    <= w_onehot;
    end else begin
      r_seg    <= '0;
      r_dp_out <= 1'b0;
      r_dig    <= '0;
    end
  end

  assign bus.seg_out    = r_seg ^ {7{SEG_INV}};
  assign bus.dp_out     = r_dp_out ^ SEG_INV;
  assign bus.dig_sel    = r_dig ^ {NUM_DIGITS{DIG_INV}};
  assign bus.frame_done = r_frame_done;

endmodule
